crc_frame_engine: RTL and testbench

CRC_FRAME_ENGINE -- requirements
Module: crc_frame_engine

---
 rtl/crc_frame_engine_if.sv | 22 ++
 rtl/crc_frame_engine.sv | 137 +++++++++++++
 tb/tb_crc_frame_engine.sv | 298 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/crc_frame_engine_if.sv
// Byte-stream bundle for crc_frame_engine: upstream input bytes and downstream output bytes.
// The engine sits on the slave modport; the driving/consuming side uses master.
interface crc_frame_engine_if;
   logic       i_valid;
   logic [7:0] i_data;
   logic       i_last;
   logic       o_ready;
   logic       o_valid;
   logic [7:0] o_data;
   logic       o_last;
   logic       i_ready;

   modport master (
      output i_valid, i_data, i_last, i_ready,
      input  o_ready, o_valid, o_data, o_last
   );

   modport slave (
      input  i_valid, i_data, i_last, i_ready,
      output o_ready, o_valid, o_data, o_last
   );
endinterface

// File: rtl/crc_frame_engine.sv
// Streaming MSB-first CRC engine: appends the CRC (MODE 0) or verifies a trailing CRC (MODE 1).
// Optional failed-frame counter is compiled in when CRC_ERR_CNT_EN is defined.
module crc_frame_engine #(
   parameter int unsigned       CRC_W = 8,
   parameter logic [CRC_W-1:0]  POLY  = CRC_W'(8'h07),
   parameter logic [CRC_W-1:0]  INIT  = '0,
   parameter int unsigned       MODE  = 0
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_init,
   crc_frame_engine_if.slave bus,
   output logic [CRC_W-1:0]  o_crc,
   output logic              o_done,
   output logic              o_crc_ok,
   output logic [15:0]       o_err_cnt
);

   localparam int unsigned NB = CRC_W / 8;

   typedef enum logic [1:0] {StData, StAppend, StDone} state_e;

   state_e           state_q;
   logic [CRC_W-1:0] crc_q;
   logic [1:0]       idx_q;
   logic             ok_q;

   logic             ready;
   logic             accept;
   logic             last_byte;
   logic [CRC_W-1:0] app_word;
   int unsigned      shamt;

   function automatic logic [CRC_W-1:0] crc_byte(input logic [CRC_W-1:0] c,
                                                 input logic [7:0] d);
      logic [CRC_W-1:0] r;
      r = c ^ (CRC_W'(d) << (CRC_W - 8));
      for (int i = 0; i < 8; i++) begin
         r = r[CRC_W-1] ? ((r << 1) ^ POLY) : (r << 1);
      end
      return r;
   endfunction

   always_comb begin
      last_byte = (idx_q == 2'(NB - 1));
      shamt     = 8 * (NB - 1 - 32'(idx_q));
      // crc_q holds the frame's final CRC for the whole append phase
      app_word  = crc_q >> shamt;
      ready       = 1'b0;
      bus.o_valid = 1'b0;
      bus.o_data  = 8'h00;
      bus.o_last  = 1'b0;
      if (MODE == 0) begin
         case (state_q)
            StData: begin
               ready       = bus.i_ready;
               bus.o_valid = bus.i_valid;
               bus.o_data  = bus.i_data;
            end
            StAppend: begin
               bus.o_valid = 1'b1;
               bus.o_data  = app_word[7:0];
               bus.o_last  = last_byte;
            end
            default: ;
         endcase
      end else begin
         ready = (state_q == StData);
      end
      bus.o_ready = ready;
      accept      = bus.i_valid & ready;
      o_done      = !i_rst && !i_init &&
                    ((state_q == StAppend && bus.i_ready && last_byte) || state_q == StDone);
      // Result is visible in the same cycle as the o_done pulse, then held in ok_q
      o_crc_ok    = (state_q == StDone) ? (crc_q == '0) : ok_q;
      o_crc       = crc_q;
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q <= StData;
         crc_q   <= INIT;
         idx_q   <= '0;
         ok_q    <= 1'b0;
      end else if (i_init) begin
         state_q <= StData;
         crc_q   <= INIT;
         idx_q   <= '0;
      end else begin
         case (state_q)
            StData: begin
               if (accept) begin
                  crc_q <= crc_byte(crc_q, bus.i_data);
                  if (bus.i_last) begin
                     state_q <= (MODE == 0) ? StAppend : StDone;
                  end
               end
            end
            StAppend: begin
               if (bus.i_ready) begin
                  if (last_byte) begin
                     idx_q   <= '0;
                     crc_q   <= INIT;
                     state_q <= StData;
                  end else begin
                     idx_q <= idx_q + 2'd1;
                  end
               end
            end
            StDone: begin
               ok_q    <= (crc_q == '0);
               crc_q   <= INIT;
               state_q <= StData;
            end
            default: state_q <= StData;
         endcase
      end
   end

`ifdef CRC_ERR_CNT_EN
   logic [15:0] err_cnt_q;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         err_cnt_q <= '0;
      end else if (MODE != 0 && !i_init && state_q == StDone && crc_q != '0 &&
                   err_cnt_q != 16'hFFFF) begin
         err_cnt_q <= err_cnt_q + 16'd1;
      end
   end

   assign o_err_cnt = err_cnt_q;
`else
   assign o_err_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_crc_frame_engine.sv
// Bench for crc_frame_engine: CRC-8 and CRC-16 generators plus a CRC-8 checker, compared against
// a polynomial long-division reference model with directed and random frames.
module tb_crc_frame_engine;

   logic sim_clk = 1'b0;
   always #5 sim_clk = ~sim_clk;

   logic       rst, init;
   logic       valid, last, rdy;
   logic [7:0] data;
   logic       cvalid, clast;
   logic [7:0] cdata;

   logic [7:0]  crc8, crcc;
   logic [15:0] crc16;
   logic        g8_done, g16_done, c_done, g8_ok, g16_ok, c_ok;
   logic [15:0] g8_err, g16_err, c_err;

   crc_frame_engine_if bus_g8();
   crc_frame_engine_if bus_g16();
   crc_frame_engine_if bus_c();

   assign bus_g8.i_valid  = valid;
   assign bus_g8.i_data   = data;
   assign bus_g8.i_last   = last;
   assign bus_g8.i_ready  = rdy;
   assign bus_g16.i_valid = valid;
   assign bus_g16.i_data  = data;
   assign bus_g16.i_last  = last;
   assign bus_g16.i_ready = rdy;
   assign bus_c.i_valid   = cvalid;
   assign bus_c.i_data    = cdata;
   assign bus_c.i_last    = clast;
   assign bus_c.i_ready   = 1'b0;

   crc_frame_engine #(.CRC_W(8), .POLY(8'h07), .INIT(8'h00), .MODE(0)) u_g8 (
      .i_clk(sim_clk), .i_rst(rst), .i_init(init), .bus(bus_g8.slave), .o_crc(crc8),
      .o_done(g8_done), .o_crc_ok(g8_ok), .o_err_cnt(g8_err)
   );

   crc_frame_engine #(.CRC_W(16), .POLY(16'h1021), .INIT(16'hFFFF), .MODE(0)) u_g16 (
      .i_clk(sim_clk), .i_rst(rst), .i_init(init), .bus(bus_g16.slave), .o_crc(crc16),
      .o_done(g16_done), .o_crc_ok(g16_ok), .o_err_cnt(g16_err)
   );

   crc_frame_engine #(.CRC_W(8), .POLY(8'h07), .INIT(8'h00), .MODE(1)) u_c (
      .i_clk(sim_clk), .i_rst(rst), .i_init(init), .bus(bus_c.slave), .o_crc(crcc),
      .o_done(c_done), .o_crc_ok(c_ok), .o_err_cnt(c_err)
   );

   int n_tests = 0;
   int n_fail  = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // CRC = (init * x^(8n) + M(x) * x^W) mod G, by long division over a bit queue
   function automatic logic [31:0] model_crc(input int w, input logic [31:0] poly,
                                             input logic [31:0] ini, input logic [7:0] fr[$]);
      bit          a[$];
      logic [32:0] g;
      logic [31:0] r;
      g = (33'd1 << w) | {1'b0, poly};
      foreach (fr[k]) for (int b = 7; b >= 0; b--) a.push_back(fr[k][b]);
      for (int i = 0; i < w; i++) a.push_back(1'b0);
      for (int i = 0; i < w; i++) a[i] = a[i] ^ ini[w-1-i];
      for (int i = 0; i < a.size() - w; i++) begin
         if (a[i]) for (int j = 0; j <= w; j++) a[i+j] = a[i+j] ^ g[w-j];
      end
      r = '0;
      for (int j = 0; j < w; j++) r[w-1-j] = a[a.size()-w+j];
      return r;
   endfunction

   logic [7:0] out8[$], out16[$];
   logic [1:0] flag8[$], flag16[$];
   int         done8 = 0, done16 = 0, donec = 0;
   logic       okc = 1'b0;
   int         err_exp = 0;

   always @(negedge sim_clk) begin
      if (bus_g8.o_valid && bus_g8.i_ready) begin
         out8.push_back(bus_g8.o_data);
         flag8.push_back({bus_g8.o_last, g8_done});
      end
      if (bus_g16.o_valid && bus_g16.i_ready) begin
         out16.push_back(bus_g16.o_data);
         flag16.push_back({bus_g16.o_last, g16_done});
      end
      if (g8_done) done8++;
      if (g16_done) done16++;
      if (c_done) begin
         donec++;
         okc = c_ok;
      end
   end

   // mode 0: ready always high, 1: random ready, 2: ready low for 3 cycles at start of append
   task automatic run_gen(input logic [7:0] fr[$], input int mode);
      logic [31:0] e8, e16;
      logic [7:0]  x8[$], x16[$];
      int          n, b8, b16, cyc;
      bit          acc;
      n   = fr.size();
      e8  = model_crc(8, 32'h07, 32'h0, fr);
      e16 = model_crc(16, 32'h1021, 32'hFFFF, fr);
      x8  = fr;
      x8.push_back(e8[7:0]);
      x16 = fr;
      x16.push_back(e16[15:8]);
      x16.push_back(e16[7:0]);
      out8.delete(); out16.delete(); flag8.delete(); flag16.delete();
      b8 = done8; b16 = done16;
      for (int i = 0; i < n; i++) begin
         valid = 1'b1; data = fr[i]; last = (i == n - 1);
         acc = 1'b0; cyc = 0;
         while (!acc && cyc < 64) begin
            rdy = (mode == 1) ? ($urandom_range(0, 3) != 0) : 1'b1;
            acc = rdy;
            @(posedge sim_clk); #1;
            cyc++;
         end
      end
      valid = 1'b0; last = 1'b0;
      check("g8_crc_final", {24'h0, crc8}, e8);
      check("g16_crc_final", {16'h0, crc16}, e16);
      if (mode == 2) begin
         for (int k = 0; k < 3; k++) begin
            rdy = 1'b0;
            #1;
            check("g8_hold", {23'h0, bus_g8.o_valid, bus_g8.o_data}, {23'h0, 1'b1, e8[7:0]});
            check("g16_hold", {23'h0, bus_g16.o_valid, bus_g16.o_data}, {23'h0, 1'b1, e16[15:8]});
            @(posedge sim_clk); #1;
         end
      end
      cyc = 0;
      while ((done8 == b8 || done16 == b16) && cyc < 40) begin
         rdy = (mode == 1) ? ($urandom_range(0, 2) != 0) : 1'b1;
         @(posedge sim_clk); #1;
         cyc++;
      end
      rdy = 1'b1;
      if (cyc >= 40) check("gen_timeout", 32'd0, 32'd1);
      check("g8_count", out8.size(), x8.size());
      check("g16_count", out16.size(), x16.size());
      for (int i = 0; i < x8.size() && i < out8.size(); i++) begin
         check("g8_byte", out8[i], x8[i]);
         check("g8_last_done", flag8[i], (i == x8.size() - 1) ? 2'b11 : 2'b00);
      end
      for (int i = 0; i < x16.size() && i < out16.size(); i++) begin
         check("g16_byte", out16[i], x16[i]);
         check("g16_last_done", flag16[i], (i == x16.size() - 1) ? 2'b11 : 2'b00);
      end
      check("g8_done_cnt", done8 - b8, 1);
      check("g16_done_cnt", done16 - b16, 1);
      check("g8_crc_reinit", {24'h0, crc8}, 32'h00);
      check("g16_crc_reinit", {16'h0, crc16}, 32'hFFFF);
   endtask

   task automatic run_chk(input logic [7:0] fr[$]);
      int b, cyc;
      bit acc, exp_ok;
      b      = donec;
      exp_ok = (model_crc(8, 32'h07, 32'h0, fr) == 32'h0);
      for (int i = 0; i < fr.size(); i++) begin
         acc = 1'b0; cyc = 0;
         while (!acc && cyc < 64) begin
            cvalid = ($urandom_range(0, 3) != 0);
            cdata  = fr[i];
            clast  = (i == fr.size() - 1);
            acc    = cvalid;
            @(posedge sim_clk); #1;
            cyc++;
         end
      end
      cvalid = 1'b0; clast = 1'b0;
      cyc = 0;
      while (donec == b && cyc < 10) begin
         @(posedge sim_clk); #1;
         cyc++;
      end
`ifdef CRC_ERR_CNT_EN
      if (!exp_ok) err_exp++;
`endif
      check("chk_done_cnt", donec - b, 1);
      check("chk_ok", {31'h0, okc}, {31'h0, exp_ok});
      check("chk_ok_held", {31'h0, c_ok}, {31'h0, exp_ok});
      check("chk_err_cnt", {16'h0, c_err}, err_exp);
      check("chk_crc_reinit", {24'h0, crcc}, 32'h0);
   endtask

   task automatic drive_byte(input logic [7:0] b, input logic l);
      valid = 1'b1; data = b; last = l; rdy = 1'b1;
      @(posedge sim_clk); #1;
      valid = 1'b0; last = 1'b0;
   endtask

   initial begin
      logic [7:0] q[$], f[$];
      logic [31:0] c;
      int d8, d16, len;
      rst = 1'b1; init = 1'b0; valid = 1'b0; last = 1'b0; rdy = 1'b1; data = 8'h00;
      cvalid = 1'b0; clast = 1'b0; cdata = 8'h00;
      repeat (3) @(posedge sim_clk);
      #1 rst = 1'b0;
      check("rst_crc8", {24'h0, crc8}, 32'h00);
      check("rst_crc16", {16'h0, crc16}, 32'hFFFF);
      check("rst_crcc", {24'h0, crcc}, 32'h00);
      check("rst_flags", {g8_done, g16_done, c_done, c_ok, bus_g8.o_valid, bus_g8.o_last}, 6'h0);
      check("rst_err", {16'h0, c_err}, 32'h0);

      q = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
      run_gen(q, 0);
      check("check_str_crc8", (out8.size() == 10) ? {24'h0, out8[9]} : 32'hDEAD, 32'hF4);
      check("check_str_crc16_hi", (out16.size() == 11) ? {24'h0, out16[9]} : 32'hDEAD, 32'h29);
      check("check_str_crc16_lo", (out16.size() == 11) ? {24'h0, out16[10]} : 32'hDEAD, 32'hB1);

      f = '{8'h00};
      run_gen(f, 0);
      check("one_byte_out", (out8.size() == 2) ? {16'h0, out8[0], out8[1]} : 32'hDEAD, 32'h0);

      run_gen(q, 2);

      f = q; f.push_back(8'hF4);
      run_chk(f);
      check("chk_good_ok", {31'h0, okc}, 32'h1);
      f = q; f.push_back(8'hF5);
      run_chk(f);
      check("chk_bad_ok", {31'h0, okc}, 32'h0);
`ifdef CRC_ERR_CNT_EN
      check("chk_bad_err", {16'h0, c_err}, 32'h1);
`else
      check("chk_bad_err", {16'h0, c_err}, 32'h0);
`endif

      // abort by i_init mid-frame
      d8 = done8; d16 = done16;
      for (int i = 0; i < 4; i++) drive_byte(q[i], 1'b0);
      init = 1'b1;
      @(posedge sim_clk); #1;
      init = 1'b0;
      check("init_crc8", {24'h0, crc8}, 32'h00);
      check("init_crc16", {16'h0, crc16}, 32'hFFFF);
      // abort by i_rst mid-append
      for (int i = 0; i < q.size(); i++) drive_byte(q[i], i == q.size() - 1);
      rdy = 1'b0;
      @(posedge sim_clk); #1;
      rst = 1'b1;
      @(posedge sim_clk); #1;
      rst = 1'b0; rdy = 1'b1;
      repeat (4) @(posedge sim_clk);
      #1;
      check("abort_no_done8", done8 - d8, 0);
      check("abort_no_done16", done16 - d16, 0);
      check("abort_idle_valid", {31'h0, bus_g8.o_valid}, 32'h0);
      err_exp = 0;
      run_gen(q, 0);
      check("after_abort_crc8", (out8.size() == 10) ? {24'h0, out8[9]} : 32'hDEAD, 32'hF4);

      // i_init with a simultaneous byte acceptance leaves the CRC at INIT
      valid = 1'b1; data = 8'h55; rdy = 1'b1; init = 1'b1;
      cvalid = 1'b1; cdata = 8'h55;
      @(posedge sim_clk); #1;
      init = 1'b0; valid = 1'b0; cvalid = 1'b0;
      check("init_wins_crc8", {24'h0, crc8}, 32'h00);
      check("init_wins_crc16", {16'h0, crc16}, 32'hFFFF);
      check("init_wins_crcc", {24'h0, crcc}, 32'h00);

      for (int t = 0; t < 25; t++) begin
         len = $urandom_range(1, 12);
         f.delete();
         for (int i = 0; i < len; i++) f.push_back(8'($urandom));
         run_gen(f, 1);
      end

      for (int t = 0; t < 25; t++) begin
         len = $urandom_range(1, 8);
         f.delete();
         for (int i = 0; i < len; i++) f.push_back(8'($urandom));
         c = model_crc(8, 32'h07, 32'h0, f);
         f.push_back(c[7:0]);
         if ($urandom_range(0, 1) == 1) begin
            len = $urandom_range(0, f.size() - 1);
            f[len] = f[len] ^ (8'h01 << $urandom_range(0, 7));
         end
         run_chk(f);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
